// File: rtl/input_to_adder_and_mul_a_input_wrt_feedback_i_pkg.sv
// Shared widths and feedback_i operand-select modes for the multiply-add slice.
package input_to_adder_and_mul_a_input_wrt_feedback_i_pkg;

    localparam int A_W = 20;
    localparam int B_W = 18;
    localparam int P_W = A_W + B_W;

    typedef enum logic [2:0] {
        FB_ACC     = 3'd0,
        FB_MUL     = 3'd1,
        FB_SHIFT_A = 3'd2,
        FB_P_MUL   = 3'd3,
        FB_COEF0   = 3'd4,
        FB_COEF1   = 3'd5,
        FB_COEF2   = 3'd6,
        FB_COEF3   = 3'd7
    } fb_mode_e;

endpackage

// File: rtl/input_to_adder_and_mul_a_input_wrt_feedback_i_if.sv
// Operand/result bundle of the slice. There is no handshake: every signal is
// sampled on each rising clk edge, and P is valid one edge after its operands.
interface input_to_adder_and_mul_a_input_wrt_feedback_i_if;
    import input_to_adder_and_mul_a_input_wrt_feedback_i_pkg::*;

    logic                  subtract_i;
    logic [2:0]            feedback_i;
    logic signed [A_W-1:0] coef_0_i;
    logic signed [A_W-1:0] coef_1_i;
    logic signed [A_W-1:0] coef_2_i;
    logic signed [A_W-1:0] coef_3_i;
    logic [3:0]            acc_fir;
    logic signed [A_W-1:0] A;
    logic signed [B_W-1:0] B;
    logic signed [P_W-1:0] P;

    modport master (
        output subtract_i, feedback_i, coef_0_i, coef_1_i, coef_2_i, coef_3_i,
        output acc_fir, A, B,
        input  P
    );

    modport slave (
        input  subtract_i, feedback_i, coef_0_i, coef_1_i, coef_2_i, coef_3_i,
        input  acc_fir, A, B,
        output P
    );

endinterface

// File: rtl/input_to_adder_and_mul_a_input_wrt_feedback_i_dsp_operand_select.sv
// Combinational operand mux: picks the multiplier A operand and the adder's
// first operand from feedback_i.
module input_to_adder_and_mul_a_input_wrt_feedback_i_dsp_operand_select
    import input_to_adder_and_mul_a_input_wrt_feedback_i_pkg::*;
(
    input  logic [2:0]            feedback_i,
    input  logic signed [A_W-1:0] a_i,
    input  logic signed [P_W-1:0] p_i,
    input  logic signed [A_W-1:0] coef_0_i,
    input  logic signed [A_W-1:0] coef_1_i,
    input  logic signed [A_W-1:0] coef_2_i,
    input  logic signed [A_W-1:0] coef_3_i,
    input  logic [3:0]            acc_fir_i,
    output logic signed [A_W-1:0] mult_a_o,
    output logic signed [P_W-1:0] add_in_o
);

    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] a_shift;

    // A is widened to the accumulator width before shifting so the shifted
    // value keeps its sign; bits pushed past P_W are simply dropped.
    assign a_ext   = {{(P_W-A_W){a_i[A_W-1]}}, a_i};
    assign a_shift = a_ext << acc_fir_i;

    always_comb begin
        mult_a_o = a_i;
        add_in_o = a_shift;
        case (feedback_i)
            FB_ACC:     add_in_o = p_i;
            FB_MUL:     add_in_o = '0;
            FB_SHIFT_A: mult_a_o = a_i;
            FB_P_MUL:   mult_a_o = p_i[A_W-1:0];
            FB_COEF0:   mult_a_o = coef_0_i;
            FB_COEF1:   mult_a_o = coef_1_i;
            FB_COEF2:   mult_a_o = coef_2_i;
            FB_COEF3:   mult_a_o = coef_3_i;
            default:    mult_a_o = a_i;
        endcase
    end

endmodule

// File: rtl/input_to_adder_and_mul_a_input_wrt_feedback_i.sv
// Single-stage signed multiply-add/accumulate slice: P <= add_in +/- mult_a*B,
// all arithmetic wrapping modulo 2^P_W.
module input_to_adder_and_mul_a_input_wrt_feedback_i
    import input_to_adder_and_mul_a_input_wrt_feedback_i_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input_to_adder_and_mul_a_input_wrt_feedback_i_if.slave bus
);

    logic signed [A_W-1:0] mult_a;
    logic signed [P_W-1:0] add_in;
    logic signed [P_W-1:0] a_wide;
    logic signed [P_W-1:0] b_wide;
    logic signed [P_W-1:0] product;
    logic signed [P_W-1:0] p_d;
    logic signed [P_W-1:0] p_q;

    input_to_adder_and_mul_a_input_wrt_feedback_i_dsp_operand_select u_dsp_operand_select (
        .feedback_i (bus.feedback_i),
        .a_i        (bus.A),
        .p_i        (p_q),
        .coef_0_i   (bus.coef_0_i),
        .coef_1_i   (bus.coef_1_i),
        .coef_2_i   (bus.coef_2_i),
        .coef_3_i   (bus.coef_3_i),
        .acc_fir_i  (bus.acc_fir),
        .mult_a_o   (mult_a),
        .add_in_o   (add_in)
    );

    // Both operands are sign-extended to P_W, so the P_W-bit product is the
    // exact full-precision signed result.
    assign a_wide  = {{B_W{mult_a[A_W-1]}}, mult_a};
    assign b_wide  = {{A_W{bus.B[B_W-1]}}, bus.B};
    assign product = a_wide * b_wide;

    assign p_d = bus.subtract_i ? (add_in - product) : (add_in + product);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign bus.P = p_q;

endmodule

// File: tb/tb_input_to_adder_and_mul_a_input_wrt_feedback_i.sv
// Self-checking bench for the multiply-add slice against a longint reference model.
module tb_input_to_adder_and_mul_a_input_wrt_feedback_i;
    import input_to_adder_and_mul_a_input_wrt_feedback_i_pkg::*;

    logic clk;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    logic signed [P_W-1:0] mp;
    logic signed [P_W-1:0] exp_p;

    input_to_adder_and_mul_a_input_wrt_feedback_i_if bus ();

    input_to_adder_and_mul_a_input_wrt_feedback_i dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    // Reference: next P from current inputs and model state mp, in plain 64-bit arithmetic.
    function automatic logic signed [P_W-1:0] model_next();
        longint ma;
        longint ai;
        longint r;
        case (bus.feedback_i)
            3'd3:    ma = longint'($signed(mp[A_W-1:0]));
            3'd4:    ma = longint'(bus.coef_0_i);
            3'd5:    ma = longint'(bus.coef_1_i);
            3'd6:    ma = longint'(bus.coef_2_i);
            3'd7:    ma = longint'(bus.coef_3_i);
            default: ma = longint'(bus.A);
        endcase
        if (bus.feedback_i == 3'd0)      ai = longint'(mp);
        else if (bus.feedback_i == 3'd1) ai = 0;
        else                             ai = longint'(bus.A) <<< bus.acc_fir;
        if (bus.subtract_i) r = ai - ma * longint'(bus.B);
        else                r = ai + ma * longint'(bus.B);
        return r[P_W-1:0];
    endfunction

    task automatic set_ops(input logic sub, input logic [2:0] fb, input logic [3:0] acc,
                           input logic signed [A_W-1:0] a, input logic signed [B_W-1:0] b);
        bus.subtract_i = sub;
        bus.feedback_i = fb;
        bus.acc_fir    = acc;
        bus.A          = a;
        bus.B          = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_p();
        set_ops(1'b0, FB_MUL, 4'd0, 20'sd0, 18'sd0);
        step();
        n_vec++;
        if (bus.P !== '0) begin
            n_err++;
            $display("FAIL clear: P=%0d expected 0", bus.P);
        end
        mp = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_ops(1'b0, FB_ACC, 4'd0, 20'sd5, 18'sd2);
        bus.coef_0_i = '0; bus.coef_1_i = '0; bus.coef_2_i = '0; bus.coef_3_i = '0;
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (bus.P !== '0) begin n_err++; $display("FAIL reset_async: P=%0d expected 0", bus.P); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (bus.P !== '0) begin n_err++; $display("FAIL reset_hold: P=%0d expected 0", bus.P); end
        end
        reset = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            step();
            exp_p = P_W'(10 * i);
            n_vec++;
            if (bus.P !== exp_p) begin n_err++; $display("FAIL reset_release: P=%0d expected %0d", bus.P, exp_p); end
        end
        #($urandom_range(1, 7)) reset = 1'b0;
        #1;
        n_vec++;
        if (bus.P !== '0) begin n_err++; $display("FAIL reset_mid_acc: P=%0d expected 0", bus.P); end
        step();
        n_vec++;
        if (bus.P !== '0) begin n_err++; $display("FAIL reset_mid_hold: P=%0d expected 0", bus.P); end
        reset = 1'b1;
        step();
        n_vec++;
        if (bus.P !== 38'sd10) begin n_err++; $display("FAIL reset_restart: P=%0d expected 10", bus.P); end
        mp = 38'sd10;
    endtask

    task automatic test_accumulate(input logic sub);
        clear_p();
        set_ops(sub, FB_ACC, 4'($urandom), 20'sd5, 18'sd2);
        for (int i = 1; i <= 3; i++) begin
            step();
            exp_p = sub ? -P_W'(10 * i) : P_W'(10 * i);
            n_vec++;
            if (bus.P !== exp_p) begin n_err++; $display("FAIL acc_directed sub=%0b: P=%0d expected %0d", sub, bus.P, exp_p); end
        end
        mp = exp_p;
        for (int i = 0; i < 32; i++) begin
            bus.A = A_W'($urandom);
            bus.B = B_W'($urandom);
            exp_p = model_next();
            step();
            mp = exp_p;
            n_vec++;
            if (bus.P !== exp_p) begin n_err++; $display("FAIL acc_random sub=%0b: P=%0d expected %0d", sub, bus.P, exp_p); end
        end
    endtask

    task automatic test_shift_feedback();
        clear_p();
        set_ops(1'b0, FB_SHIFT_A, 4'd1, 20'sd5, 18'sd2);
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++;
            if (bus.P !== 38'sd20) begin n_err++; $display("FAIL shift_a: P=%0d expected 20", bus.P); end
        end
        bus.feedback_i = FB_P_MUL;
        step();
        n_vec++;
        if (bus.P !== 38'sd50) begin n_err++; $display("FAIL p_mul_1: P=%0d expected 50", bus.P); end
        step();
        n_vec++;
        if (bus.P !== 38'sd110) begin n_err++; $display("FAIL p_mul_2: P=%0d expected 110", bus.P); end
        mp = 38'sd110;
    endtask

    task automatic test_coef();
        bus.coef_0_i = 20'sd5;
        bus.coef_1_i = 20'sd7;
        bus.coef_2_i = -20'sd9;
        bus.coef_3_i = 20'sd5;
        set_ops(1'b0, FB_COEF0, 4'd1, 20'sd15, 18'sd12);
        step();
        n_vec++;
        if (bus.P !== 38'sd90) begin n_err++; $display("FAIL coef0: P=%0d expected 90", bus.P); end
        bus.subtract_i = 1'b1;
        bus.feedback_i = FB_COEF3;
        step();
        n_vec++;
        if (bus.P !== -38'sd30) begin n_err++; $display("FAIL coef3_sub: P=%0d expected -30", bus.P); end
        mp = -38'sd30;
        for (int i = 0; i < 16; i++) begin
            bus.coef_0_i = A_W'($urandom);
            bus.coef_1_i = A_W'($urandom);
            bus.coef_2_i = A_W'($urandom);
            bus.coef_3_i = A_W'($urandom);
            set_ops(1'($urandom), 3'(4 + (i % 4)), 4'($urandom), A_W'($urandom), B_W'($urandom));
            exp_p = model_next();
            step();
            mp = exp_p;
            n_vec++;
            if (bus.P !== exp_p) begin n_err++; $display("FAIL coef_random mode=%0d: P=%0d expected %0d", bus.feedback_i, bus.P, exp_p); end
        end
    endtask

    task automatic test_boundaries();
        set_ops(1'b0, FB_MUL, 4'd0, -20'sd524288, -18'sd131072);
        step();
        n_vec++;
        if (bus.P !== 38'sh10_0000_0000) begin n_err++; $display("FAIL min_times_min: P=%0d expected 68719476736", bus.P); end
        bus.feedback_i = FB_ACC;
        step();
        n_vec++;
        if (bus.P !== 38'sh20_0000_0000) begin n_err++; $display("FAIL acc_wrap: P=%0d expected -137438953472", bus.P); end
        set_ops(1'b0, FB_SHIFT_A, 4'd15, -20'sd1, 18'sd0);
        step();
        n_vec++;
        if (bus.P !== -38'sd32768) begin n_err++; $display("FAIL shift_max: P=%0d expected -32768", bus.P); end
        mp = -38'sd32768;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 64; i++) begin
            bus.coef_0_i = A_W'($urandom);
            bus.coef_1_i = A_W'($urandom);
            bus.coef_2_i = A_W'($urandom);
            bus.coef_3_i = A_W'($urandom);
            set_ops(1'($urandom), 3'($urandom_range(0, 7)), 4'($urandom), A_W'($urandom), B_W'($urandom));
            exp_p = model_next();
            step();
            mp = exp_p;
            n_vec++;
            if (bus.P !== exp_p) begin n_err++; $display("FAIL b2b mode=%0d: P=%0d expected %0d", bus.feedback_i, bus.P, exp_p); end
        end
    endtask

    initial begin
        mp = '0;
        test_reset();
        test_accumulate(1'b0);
        test_accumulate(1'b1);
        test_shift_feedback();
        test_coef();
        test_boundaries();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
